// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video RAM arbiter: fixed-latency video fetch port with CPU req/ack on spare cycles
module vram_arbiter #(
    parameter int ADDR_W        = 12,
    parameter int MEM_LATENCY   = 2,
    parameter int VIDEO_LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    input  logic              vid_rd_strobe_i,
    output logic [15:0]       vid_data_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [15:0]       cpu_wdata_i,
    input  logic [1:0]        cpu_be_i,
    output logic              cpu_ack_o,
    output logic [15:0]       cpu_rdata_o,
    output logic              cpu_rvalid_o,
    output logic [7:0]        cpu_wait_max_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_en_o,
    output logic [1:0]        mem_we_o,
    output logic [15:0]       mem_wdata_o,
    input  logic [15:0]       mem_rdata_i
);

    localparam int DLY = VIDEO_LATENCY - MEM_LATENCY;

    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU_RD} tag_e;
    typedef enum logic {S_IDLE, S_WAITING} state_e;

    generate
        if (VIDEO_LATENCY < MEM_LATENCY || MEM_LATENCY < 1) begin : g_param_check
            $error("vram_arbiter: need VIDEO_LATENCY >= MEM_LATENCY >= 1");
        end
    endgenerate

    logic   vid_issue;
    logic   cpu_issue;
    tag_e   tag_in;
    tag_e   tag_q [MEM_LATENCY];
    tag_e   tag_out;

    // Video always wins the memory cycle; the CPU only gets cycles with no strobe.
    always_comb begin
        vid_issue   = vid_rd_strobe_i && !rst_i;
        cpu_issue   = cpu_req_i && !vid_rd_strobe_i && !rst_i;
        mem_en_o    = vid_issue || cpu_issue;
        mem_addr_o  = vid_rd_strobe_i ? vid_addr_i : cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        mem_we_o    = (cpu_issue && cpu_we_i) ? cpu_be_i : 2'b00;
        cpu_ack_o   = cpu_issue;
        if (vid_issue) begin
            tag_in = TAG_VID;
        end else if (cpu_issue && !cpu_we_i) begin
            tag_in = TAG_CPU_RD;
        end else begin
            tag_in = TAG_NONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[MEM_LATENCY-1];

    logic        vid_src_vld;
    logic [15:0] vid_src_data;
    logic [15:0] vid_hold_q;

    // Pad the memory latency up to the fixed video latency.
    generate
        if (DLY == 0) begin : g_vid_direct
            assign vid_src_vld  = (tag_out == TAG_VID);
            assign vid_src_data = mem_rdata_i;
        end else begin : g_vid_delay
            logic [15:0]    dly_data_q [DLY];
            logic [DLY-1:0] dly_vld_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < DLY; k++) begin
                        dly_data_q[k] <= '0;
                    end
                    dly_vld_q <= '0;
                end else begin
                    dly_data_q[0] <= mem_rdata_i;
                    dly_vld_q[0]  <= (tag_out == TAG_VID);
                    for (int k = 1; k < DLY; k++) begin
                        dly_data_q[k] <= dly_data_q[k-1];
                        dly_vld_q[k]  <= dly_vld_q[k-1];
                    end
                end
            end

            assign vid_src_vld  = dly_vld_q[DLY-1];
            assign vid_src_data = dly_data_q[DLY-1];
        end
    endgenerate

    assign vid_data_o = vid_src_vld ? vid_src_data : vid_hold_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vid_hold_q <= '0;
        end else begin
            vid_hold_q <= vid_data_o;
        end
    end

    logic [15:0] cpu_rdata_q;
    logic        cpu_rvalid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= (tag_out == TAG_CPU_RD);
            if (tag_out == TAG_CPU_RD) begin
                cpu_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign cpu_rdata_o  = cpu_rdata_q;
    assign cpu_rvalid_o = cpu_rvalid_q;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] wait_max_q, wait_max_d;
    logic [7:0] wait_now;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            wait_max_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wait_max_q <= wait_max_d;
        end
    end

    // wait_now counts the current WAITING cycle, so a single blocked cycle reports 1.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wait_max_d = wait_max_q;
        wait_now   = 8'd0;
        if (state_q == S_WAITING) begin
            wait_now = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = 8'd0;
                if (cpu_req_i && vid_rd_strobe_i) begin
                    state_d = S_WAITING;
                end
            end
            S_WAITING: begin
                wait_cnt_d = wait_now;
                if (cpu_ack_o) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
        if (cpu_ack_o && (wait_now > wait_max_q)) begin
            wait_max_d = wait_now;
        end
    end

    assign cpu_wait_max_o = wait_max_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with a 2-cycle memory model
module tb_vram_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_strobe;
    logic [15:0]       vid_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic [1:0]        cpu_be;
    logic              cpu_ack;
    logic [15:0]       cpu_rdata;
    logic              cpu_rvalid;
    logic [7:0]        cpu_wait_max;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [1:0]        mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W        (ADDR_W),
        .MEM_LATENCY   (2),
        .VIDEO_LATENCY (3)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .vid_addr_i      (vid_addr),
        .vid_rd_strobe_i (vid_strobe),
        .vid_data_o      (vid_data),
        .cpu_req_i       (cpu_req),
        .cpu_we_i        (cpu_we),
        .cpu_addr_i      (cpu_addr),
        .cpu_wdata_i     (cpu_wdata),
        .cpu_be_i        (cpu_be),
        .cpu_ack_o       (cpu_ack),
        .cpu_rdata_o     (cpu_rdata),
        .cpu_rvalid_o    (cpu_rvalid),
        .cpu_wait_max_o  (cpu_wait_max),
        .mem_addr_o      (mem_addr),
        .mem_en_o        (mem_en),
        .mem_we_o        (mem_we),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata)
    );

    logic [15:0] vram    [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [15:0] rd_p1, rd_p2;

    assign mem_rdata = rd_p2;

    always @(posedge clk) begin
        rd_p2 <= rd_p1;
        rd_p1 <= vram[mem_addr];
        if (mem_en && mem_we[0]) vram[mem_addr][7:0]  = mem_wdata[7:0];
        if (mem_en && mem_we[1]) vram[mem_addr][15:8] = mem_wdata[15:8];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t vid_q[$];
    exp_t cpu_q[$];
    exp_t ce, ve;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 0);
            end else begin
                ce = cpu_q.pop_front();
                check("cpu_rdata", 32'(cpu_rdata), 32'(ce.data));
                check("cpu_rd_latency", cyc, ce.due);
            end
        end
        while (vid_q.size() > 0 && vid_q[0].due < cyc) begin
            ve = vid_q.pop_front();
            check("vid_missed", cyc, ve.due);
        end
        if (vid_q.size() > 0 && vid_q[0].due == cyc) begin
            ve = vid_q.pop_front();
            check("vid_data", 32'(vid_data), 32'(ve.data));
        end
    end

    task automatic vid_push(input logic [ADDR_W-1:0] a);
        vid_strobe = 1'b1;
        vid_addr   = a;
        vid_q.push_back('{due: cyc + 3, data: ref_mem[a]});
    endtask

    task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] wd,
                          input logic [1:0] be, input int limit, output int waited);
        bit got;
        got       = 1'b0;
        waited    = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_be    = be;
        for (;;) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
            waited++;
            step();
            if (waited > limit) break;
        end
        if (got) begin
            if (we) begin
                if (be[0]) ref_mem[a][7:0]  = wd[7:0];
                if (be[1]) ref_mem[a][15:8] = wd[15:8];
            end else begin
                cpu_q.push_back('{due: cyc + 3, data: ref_mem[a]});
            end
            step();
        end else begin
            check("cpu_ack_timeout", 0, 1);
        end
        cpu_req = 1'b0;
    endtask

    int          w;
    logic        r_we;
    logic [11:0] r_addr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; vid_strobe = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        for (int i = 0; i < 4096; i++) begin
            vram[i]    = 16'(i * 40503) ^ 16'h1357;
            ref_mem[i] = vram[i];
        end
        vram[12'h010] = 16'hA5A5; ref_mem[12'h010] = 16'hA5A5;
        vram[12'h011] = 16'h5A5A; ref_mem[12'h011] = 16'h5A5A;
        vram[12'h000] = 16'h0000; ref_mem[12'h000] = 16'h0000;

        // reset: issue outputs forced low even with requests present
        step();
        vid_strobe = 1'b1; vid_addr = 12'h005;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11;
        @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        step();
        rst = 1'b0; vid_strobe = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00;
        @(negedge clk);
        check("rst_vid_data", 32'(vid_data), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_wait_max", 32'(cpu_wait_max), 0);
        check("idle_mem_en", 32'(mem_en), 0);
        step();

        // video latency, back-to-back strobes
        vid_push(12'h010);
        @(negedge clk);
        check("vid_mem_en", 32'(mem_en), 1);
        check("vid_mem_we", 32'(mem_we), 0);
        check("vid_mem_addr", 32'(mem_addr), 32'h010);
        step();
        vid_push(12'h011);
        step();
        vid_strobe = 1'b0;
        repeat (5) step();

        // collision: video wins, CPU write goes one cycle later
        vid_push(12'h011);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_wdata = 16'h1234; cpu_be = 2'b11;
        @(negedge clk);
        check("coll_ack_blocked", 32'(cpu_ack), 0);
        check("coll_vid_addr", 32'(mem_addr), 32'h011);
        step();
        vid_strobe = 1'b0;
        @(negedge clk);
        check("coll_ack", 32'(cpu_ack), 1);
        check("coll_mem_we", 32'(mem_we), 32'h3);
        check("coll_mem_addr", 32'(mem_addr), 32'h020);
        ref_mem[12'h020] = 16'h1234;
        step();
        cpu_req = 1'b0;
        @(negedge clk);
        check("coll_mem_data", 32'(vram[12'h020]), 32'h1234);
        check("coll_wait_max", 32'(cpu_wait_max), 1);
        step();
        repeat (4) step();

        // byte-enable write then read-back
        cpu_op(1'b1, 12'h000, 16'hBEEF, 2'b01, 10, w);
        check("be_wr_wait", w, 0);
        cpu_op(1'b0, 12'h000, 16'h0000, 2'b00, 10, w);
        check("be_rd_wait", w, 0);
        repeat (4) step();
        check("be_rdata", 32'(cpu_rdata), 32'h00EF);

        // zero byte-enable write is a no-op
        cpu_op(1'b1, 12'h000, 16'hFFFF, 2'b00, 10, w);
        check("be0_mem_data", 32'(vram[12'h000]), 32'h00EF);

        // starvation by a 300-strobe burst
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    vid_push(12'(256 + (i % 256)));
                    step();
                end
                vid_strobe = 1'b0;
            end
            begin
                cpu_op(1'b0, 12'h020, 16'h0000, 2'b00, 400, w);
            end
        join
        check("starve_wait", w, 300);
        check("starve_wait_max", 32'(cpu_wait_max), 255);
        repeat (6) step();

        // reset one cycle after a CPU read ack drops the read
        cpu_op(1'b0, 12'h010, 16'h0000, 2'b00, 10, w);
        rst = 1'b1;
        cpu_q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_vid_data", 32'(vid_data), 0);
        check("mrst_cpu_rdata", 32'(cpu_rdata), 0);
        check("mrst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("mrst_wait_max", 32'(cpu_wait_max), 0);
        check("mrst_cpu_ack", 32'(cpu_ack), 0);
        check("mrst_mem_en", 32'(mem_en), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("mrst_no_rvalid", 32'(cpu_rvalid), 0);
        end
        step();

        // randomized traffic; CPU writes stay out of the video address range
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    if ($urandom_range(0, 1) == 1) vid_push(12'(256 + $urandom_range(0, 255)));
                    else vid_strobe = 1'b0;
                    step();
                end
                vid_strobe = 1'b0;
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    r_we   = 1'($urandom_range(0, 1));
                    r_addr = r_we ? 12'($urandom_range(0, 255)) : 12'($urandom_range(0, 511));
                    cpu_op(r_we, r_addr, 16'($urandom), 2'($urandom_range(0, 3)), 200, w);
                    if ($urandom_range(0, 2) == 0) step();
                end
            end
        join
        repeat (8) step();
        check("vid_q_drained", vid_q.size(), 0);
        check("cpu_q_drained", cpu_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
